// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
//   slot_t     : one entry of the in-flight shadow table. Register indices are
//                stored zero-extended to MAX_REG_BITS so that a single packed
//                type serves every REG_BITS setting.
//   FWD_NONE   : forwarding select meaning "use the ID/EX register value".
//   fwd_width  : width of a forwarding select for a given DEPTH.
//   cnt_width  : width of the in-flight counter for a given DEPTH.
package hazard_pkg;

  localparam int unsigned MAX_REG_BITS = 8;
  localparam int unsigned FWD_NONE     = 0;

  typedef struct packed {
    logic                    valid;
    logic [MAX_REG_BITS-1:0] rd;
    logic [MAX_REG_BITS-1:0] rs1;
    logic [MAX_REG_BITS-1:0] rs2;
    logic                    reg_write;
    logic                    mem_read;
  } slot_t;

  function automatic int unsigned fwd_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Hazard-unit interface between the pipeline control (master) and the hazard
// unit (slave).
//   id_*            : instruction currently in ID
//   ex_branch_taken : branch/jump resolved taken in EX
//   stall           : hold PC and IF/ID, bubble into EX
//   flush_ifid      : invalidate IF/ID
//   fwd_rs1/fwd_rs2 : EX operand source, 0 = ID/EX register, k = slot k+1
//   inflight        : number of valid slots
// Optional macro HAZARD_PERF_EN adds the stall_cycles and flush_count counters.
interface pipe_hazard_unit_if
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned REG_BITS = 5
);
  logic                        id_valid;
  logic [REG_BITS-1:0]         id_rs1;
  logic [REG_BITS-1:0]         id_rs2;
  logic                        id_rs1_used;
  logic                        id_rs2_used;
  logic [REG_BITS-1:0]         id_rd;
  logic                        id_reg_write;
  logic                        id_mem_read;
  logic                        ex_branch_taken;
  logic                        stall;
  logic                        flush_ifid;
  logic [fwd_width(DEPTH)-1:0] fwd_rs1;
  logic [fwd_width(DEPTH)-1:0] fwd_rs2;
  logic [cnt_width(DEPTH)-1:0] inflight;
`ifdef HAZARD_PERF_EN
  logic [31:0]                 stall_cycles;
  logic [31:0]                 flush_count;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_mem_read, ex_branch_taken,
`ifdef HAZARD_PERF_EN
    input  stall_cycles, flush_count,
`endif
    input  stall, flush_ifid, fwd_rs1, fwd_rs2, inflight
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_mem_read, ex_branch_taken,
`ifdef HAZARD_PERF_EN
    output stall_cycles, flush_count,
`endif
    output stall, flush_ifid, fwd_rs1, fwd_rs2, inflight
  );

endinterface

// File: rtl/hazard_match.sv
// Combinational priority finder over a window of N slots (index 0 = youngest).
//   op      : operand register index (zero when the operand is unused)
//   slots   : window of the shadow table
//   found   : some slot writes op (x0 never matches)
//   idx     : window position of the youngest matching slot
//   is_load : that slot is a load
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [MAX_REG_BITS-1:0] op,
  input  slot_t                   slots [N],
  output logic                    found,
  output logic [IDX_W-1:0]        idx,
  output logic                    is_load
);

  always_comb begin
    found   = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    // Scan oldest to youngest so the youngest match is the one left standing.
    for (int unsigned j = 0; j < N; j++) begin
      if (slots[N-1-j].valid && slots[N-1-j].reg_write &&
          slots[N-1-j].rd == op && op != '0) begin
        found   = 1'b1;
        idx     = IDX_W'(N - 1 - j);
        is_load = slots[N-1-j].mem_read;
      end
    end
  end

  // Source indices are carried in the table but never matched against here.
  logic unused_rs;
  always_comb begin
    unused_rs = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      unused_rs = unused_rs ^ (^{slots[j].rs1, slots[j].rs2});
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the in-order pipeline. Keeps a shadow table
// of DEPTH post-ID slots (slot 1 = EX ... slot DEPTH = WB) and derives the
// load-use stall, EX forwarding selects and branch flush from it.
//   clk, reset : clock, asynchronous active-high reset
//   hz         : pipe_hazard_unit_if.slave (ID instruction, branch, outputs)
// Optional macro HAZARD_PERF_EN adds saturating stall_cycles/flush_count.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 3,
  parameter int unsigned REG_BITS   = 5
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_unit_if.slave   hz
);

  localparam int unsigned FW = fwd_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  // slots[i] holds pipeline slot k = i+1.
  slot_t               slots   [DEPTH];
  slot_t               st_win  [DEPTH-1];
  slot_t               fw_win  [DEPTH-1];
  logic [CW-1:0]       inflight_q;

  // An unused operand is recorded as x0 so it can never match a producer.
  logic [MAX_REG_BITS-1:0] id_op1, id_op2;
  assign id_op1 = hz.id_rs1_used ? MAX_REG_BITS'(hz.id_rs1) : '0;
  assign id_op2 = hz.id_rs2_used ? MAX_REG_BITS'(hz.id_rs2) : '0;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      st_win[i] = slots[i];
      fw_win[i] = slots[i+1];
    end
  end

  logic          s1_found, s2_found, s1_load, s2_load;
  logic          f1_found, f2_found, f1_load, f2_load;
  logic [FW-1:0] s1_idx, s2_idx, f1_idx, f2_idx;

  hazard_match #(.N(DEPTH-1), .IDX_W(FW)) u_stall_rs1 (
    .op(id_op1), .slots(st_win), .found(s1_found), .idx(s1_idx), .is_load(s1_load));
  hazard_match #(.N(DEPTH-1), .IDX_W(FW)) u_stall_rs2 (
    .op(id_op2), .slots(st_win), .found(s2_found), .idx(s2_idx), .is_load(s2_load));
  hazard_match #(.N(DEPTH-1), .IDX_W(FW)) u_fwd_rs1 (
    .op(slots[0].rs1), .slots(fw_win), .found(f1_found), .idx(f1_idx), .is_load(f1_load));
  hazard_match #(.N(DEPTH-1), .IDX_W(FW)) u_fwd_rs2 (
    .op(slots[0].rs2), .slots(fw_win), .found(f2_found), .idx(f2_idx), .is_load(f2_load));

  // Stall window position idx is slot k = idx+1; the load is late when k+1 < LOAD_READY.
  logic hit1, hit2, stall_c, flush_c, take_id;
  assign hit1    = s1_found && s1_load && (32'(s1_idx) + 32'd2 < LOAD_READY);
  assign hit2    = s2_found && s2_load && (32'(s2_idx) + 32'd2 < LOAD_READY);
  assign flush_c = hz.ex_branch_taken && !reset;
  assign stall_c = hz.id_valid && !hz.ex_branch_taken && !reset && (hit1 || hit2);
  assign take_id = hz.id_valid && !stall_c && !hz.ex_branch_taken;

  // The stall rule keeps young loads out of the window, so the load flag is moot here.
  logic unused_fwd_load;
  assign unused_fwd_load = f1_load ^ f2_load;

  // Forward window position idx is slot k = idx+2, so select = k-1 = idx+1.
  assign hz.fwd_rs1    = f1_found ? (f1_idx + FW'(1)) : FW'(FWD_NONE);
  assign hz.fwd_rs2    = f2_found ? (f2_idx + FW'(1)) : FW'(FWD_NONE);
  assign hz.stall      = stall_c;
  assign hz.flush_ifid = flush_c;
  assign hz.inflight   = inflight_q;

  slot_t         id_slot;
  logic [CW-1:0] next_cnt;
  always_comb begin
    id_slot           = '0;
    id_slot.valid     = 1'b1;
    id_slot.rd        = MAX_REG_BITS'(hz.id_rd);
    id_slot.rs1       = id_op1;
    id_slot.rs2       = id_op2;
    id_slot.reg_write = hz.id_reg_write;
    id_slot.mem_read  = hz.id_mem_read;
    next_cnt          = CW'(take_id);
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      next_cnt = next_cnt + CW'(slots[i].valid);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
      inflight_q <= '0;
    end else begin
      slots[0] <= take_id ? id_slot : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        slots[i] <= slots[i-1];
      end
      inflight_q <= next_cnt;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hz.stall_cycles <= '0;
      hz.flush_count  <= '0;
    end else begin
      if (stall_c && hz.stall_cycles != '1) hz.stall_cycles <= hz.stall_cycles + 32'd1;
      if (flush_c && hz.flush_count != '1)  hz.flush_count  <= hz.flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

  localparam int DEPTH = 3;
  localparam int LR    = 3;
  localparam int RB    = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.DEPTH(DEPTH), .REG_BITS(RB)) hz ();

  pipe_hazard_unit #(.DEPTH(DEPTH), .LOAD_READY(LR), .REG_BITS(RB)) dut (
    .clk(clk), .reset(reset), .hz(hz)
  );

  typedef struct {
    bit v; int rd; int rs1; int rs2; bit u1; bit u2; bit we; bit ld;
  } ins_t;

  ins_t m [1:DEPTH];   // reference table: m[1] = EX ... m[DEPTH] = WB
  ins_t BUB;
  int checks = 0;
  int failures = 0;
  logic [31:0] obs_stall, obs_flush, obs_f1, obs_f2, obs_infl;
  bit exp_stall_last;
`ifdef HAZARD_PERF_EN
  logic [31:0] exp_sc = 0, exp_fc = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic ins_t alu(input int rd, input int rs1, input int rs2);
    ins_t t = '{v:1, rd:rd, rs1:rs1, rs2:rs2, u1:1, u2:1, we:1, ld:0};
    return t;
  endfunction
  function automatic ins_t addi(input int rd, input int rs1);
    ins_t t = '{v:1, rd:rd, rs1:rs1, rs2:0, u1:1, u2:0, we:1, ld:0};
    return t;
  endfunction
  function automatic ins_t lw(input int rd, input int rs1);
    ins_t t = '{v:1, rd:rd, rs1:rs1, rs2:0, u1:1, u2:0, we:1, ld:1};
    return t;
  endfunction

  // Does table entry k produce register r for an operand whose used bit is u?
  function automatic bit produces(input int k, input int r, input bit u);
    return m[k].v && m[k].we && m[k].rd == r && r != 0 && u;
  endfunction

  function automatic int youngest(input int lo, input int hi, input int r, input bit u);
    for (int k = lo; k <= hi; k++) if (produces(k, r, u)) return k;
    return 0;
  endfunction

  task automatic expect_now(input ins_t id, input bit br, input bit rst,
                            output bit st, output int f1, output int f2, output int cnt);
    int k1, k2;
    st = 0; f1 = 0; f2 = 0; cnt = 0;
    k1 = youngest(1, DEPTH-1, id.rs1, id.u1);
    k2 = youngest(1, DEPTH-1, id.rs2, id.u2);
    if (!rst && id.v && !br) begin
      if (k1 != 0 && m[k1].ld && k1 + 1 < LR) st = 1;
      if (k2 != 0 && m[k2].ld && k2 + 1 < LR) st = 1;
    end
    if (m[1].v) begin
      k1 = youngest(2, DEPTH, m[1].rs1, m[1].u1);
      k2 = youngest(2, DEPTH, m[1].rs2, m[1].u2);
      f1 = (k1 == 0) ? 0 : k1 - 1;
      f2 = (k2 == 0) ? 0 : k2 - 1;
    end
    for (int k = 1; k <= DEPTH; k++) cnt += m[k].v;
  endtask

  task automatic drive(input ins_t id, input bit br);
    hz.id_valid        = id.v;
    hz.id_rd           = RB'(id.rd);
    hz.id_rs1          = RB'(id.rs1);
    hz.id_rs2          = RB'(id.rs2);
    hz.id_rs1_used     = id.u1;
    hz.id_rs2_used     = id.u2;
    hz.id_reg_write    = id.we;
    hz.id_mem_read     = id.ld;
    hz.ex_branch_taken = br;
  endtask

  task automatic sample_and_check(input string tag, input ins_t id, input bit br);
    bit st; int f1, f2, cnt;
    expect_now(id, br, reset, st, f1, f2, cnt);
    obs_stall = 32'(hz.stall);
    obs_flush = 32'(hz.flush_ifid);
    obs_f1    = 32'(hz.fwd_rs1);
    obs_f2    = 32'(hz.fwd_rs2);
    obs_infl  = 32'(hz.inflight);
    chk({tag, "_stall"}, obs_stall, 32'(st));
    chk({tag, "_flush"}, obs_flush, 32'(br && !reset));
    chk({tag, "_fwd1"},  obs_f1, f1);
    chk({tag, "_fwd2"},  obs_f2, f2);
    chk({tag, "_infl"},  obs_infl, cnt);
`ifdef HAZARD_PERF_EN
    chk({tag, "_scyc"},  hz.stall_cycles, exp_sc);
    chk({tag, "_fcnt"},  hz.flush_count, exp_fc);
`endif
    exp_stall_last = st;
  endtask

  task automatic advance(input ins_t id, input bit br);
`ifdef HAZARD_PERF_EN
    if (exp_stall_last && exp_sc != '1) exp_sc++;
    if (br && exp_fc != '1) exp_fc++;
`endif
    for (int k = DEPTH; k >= 2; k--) m[k] = m[k-1];
    m[1] = (id.v && !exp_stall_last && !br) ? id : BUB;
  endtask

  // One pipeline cycle, entered and left at a falling edge.
  task automatic cyc(input string tag, input ins_t id, input bit br = 0);
    drive(id, br);
    #1;
    sample_and_check(tag, id, br);
    @(posedge clk);
    advance(id, br);
    @(negedge clk);
  endtask

  initial begin
    ins_t cur, prod;
    bit br;
    BUB = '{v:0, rd:0, rs1:0, rs2:0, u1:0, u2:0, we:0, ld:0};
    for (int k = 1; k <= DEPTH; k++) m[k] = BUB;
    reset = 1'b1;
    drive(BUB, 1'b1);
    @(negedge clk);
    #1;
    sample_and_check("rst", BUB, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back ALU dependency.
    cyc("t1_p", alu(5, 1, 2));
    cyc("t1_c", alu(6, 5, 0));
    chk("t1_nostall", obs_stall, 0);
    cyc("t1_ex", BUB);
    chk("t1_f1", obs_f1, 1);
    chk("t1_f2", obs_f2, 0);

    // Load-use: one stall, then forward from MEM/WB.
    cyc("t2_lw", lw(5, 1));
    cyc("t2_use", alu(6, 5, 5));
    chk("t2_stall1", obs_stall, 1);
    cyc("t2_hold", alu(6, 5, 5));
    chk("t2_stall2", obs_stall, 0);
    cyc("t2_ex", BUB);
    chk("t2_f1", obs_f1, 2);
    chk("t2_f2", obs_f2, 2);
    chk("t2_infl", obs_infl, 2);

    // x0 never produces.
    cyc("t3_a", addi(0, 0));
    cyc("t3_b", alu(6, 0, 0));
    cyc("t3_c", lw(0, 1));
    cyc("t3_d", alu(7, 0, 0));
    chk("t3_nostall", obs_stall, 0);
    cyc("t3_e", BUB);
    chk("t3_f1", obs_f1, 0);

    // Youngest producer wins.
    cyc("t4_o", alu(7, 1, 1));
    cyc("t4_y", alu(7, 2, 2));
    cyc("t4_c", alu(8, 7, 0));
    cyc("t4_ex", BUB);
    chk("t4_f1", obs_f1, 1);

    // Branch squashes a would-be load-use stall.
    cyc("t5_lw", lw(5, 1));
    cyc("t5_br", alu(6, 5, 5), 1'b1);
    chk("t5_stall", obs_stall, 0);
    chk("t5_flush", obs_flush, 1);
    cyc("t5_nx", BUB);
    chk("t5_f1", obs_f1, 0);

    // Asynchronous reset pulse between edges.
    cyc("t6_a", alu(1, 2, 3));
    cyc("t6_b", alu(2, 1, 1));
    cyc("t6_c", lw(3, 2));
    prod = alu(4, 3, 3);
    drive(prod, 1'b0);
    #1;
    sample_and_check("t6_pre", prod, 1'b0);
    chk("t6_pre_stall", obs_stall, 1);
    reset = 1'b1;
    for (int k = 1; k <= DEPTH; k++) m[k] = BUB;
`ifdef HAZARD_PERF_EN
    exp_sc = 0; exp_fc = 0;
`endif
    #1;
    sample_and_check("t6_in", prod, 1'b0);
    chk("t6_in_infl", obs_infl, 0);
    reset = 1'b0;
    #1;
    sample_and_check("t6_rel", prod, 1'b0);
    @(posedge clk);
    advance(prod, 1'b0);
    @(negedge clk);
    cyc("t6_ex", BUB);
    chk("t6_f1", obs_f1, 0);
    chk("t6_infl", obs_infl, 1);

    // Randomized traffic; the ID instruction is held while stalled.
    cur = alu(1, 2, 3);
    for (int n = 0; n < 300; n++) begin
      br = ($urandom_range(0, 7) == 0);
      cyc("rnd", cur, br);
      if (!(exp_stall_last && !br)) begin
        cur.v   = ($urandom_range(0, 7) != 0);
        cur.rd  = $urandom_range(0, 7);
        cur.rs1 = $urandom_range(0, 7);
        cur.rs2 = $urandom_range(0, 7);
        cur.u1  = $urandom_range(0, 1);
        cur.u2  = $urandom_range(0, 1);
        cur.ld  = ($urandom_range(0, 2) == 0);
        cur.we  = cur.ld || ($urandom_range(0, 7) != 0);
        if (cur.ld) cur.u2 = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
